// File: rtl/regfile_2r1w_init.sv
// regfile_2r1w_init: DATA_W x 2**ADDR_W register file, two registered read
// ports, one write port, register 0 hardwired to zero. A synchronous reset or
// a soft-clear pulse starts a sweep that zeroes one entry per cycle. Because
// the array is only ever written one word per cycle, it can still map to RAM.
// Optional macro REGFILE_BYPASS_EN: when it is defined, a write and a read to
// the same nonzero address in one cycle return the new data (write-first).
// When it is undefined, that read returns the old data (read-first).
module regfile_2r1w_init #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              WB,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] RegData1,
  output logic [DATA_W-1:0] RegData2,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;
  logic              w_sweep_we;
  logic              w_user_we;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  assign busy      = (r_state == INIT);
  assign w_user_we = (r_state == READY) && WB && (writeReg != '0);
  assign RegData1  = r_rd1;
  assign RegData2  = r_rd2;

  // Sweep sequencing: step idx while INIT, restart on clr, leave after the last entry.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sweep_we  = 1'b0;
    unique case (r_state)
      INIT: begin
        if (clr) begin
          w_idx_nxt = '0;
        end else begin
          w_sweep_we = 1'b1;
          w_idx_nxt  = r_idx + ADDR_W'(1);
          if (r_idx == ADDR_W'(DEPTH - 1)) w_state_nxt = READY;
        end
      end
      READY: begin
        if (clr) begin
          w_state_nxt = INIT;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Read data for the next edge: zero for r0 or during the sweep, else array (or forwarded write).
  always_comb begin
    w_rd1 = r_mem[readReg1];
    w_rd2 = r_mem[readReg2];
`ifdef REGFILE_BYPASS_EN
    if (w_user_we && (writeReg == readReg1)) w_rd1 = writeData;
    if (w_user_we && (writeReg == readReg2)) w_rd2 = writeData;
`endif
    if (busy || (readReg1 == '0)) w_rd1 = '0;
    if (busy || (readReg2 == '0)) w_rd2 = '0;
  end

  // State, sweep index and registered read data; rst has priority over clr and WB.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      r_state <= INIT;
      r_idx   <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rd1   <= w_rd1;
      r_rd2   <= w_rd2;
    end
  end

  // Array write port: the sweep zeroes in INIT, user writes land in READY; never both.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch, so it stays RAM-inferable; the sweep clears it.
    if (!rst) begin
      if (w_sweep_we) begin
        r_mem[r_idx] <= '0;
      end else if (w_user_we) begin
        r_mem[writeReg] <= writeData;
      end
    end
  end

endmodule
